ibis_lighting_multi: RTL

- Multi-light, multi-channel successor to the single-light 8-bit value lighting stage in the Ibis pixel path.
- Per pixel: evaluates LIGHTS point lights in sequence, keeps the nearest in-range attenuation coefficient, and blends CHANNELS 8-bit components between a lit value (value_in0) and an unlit value (value_in1).
- Replaces the free-running ring counter with valid/ready handshakes on the pixel input and output.
- Adds a per-light config port guarded by a ready signal.

---
 rtl/ibis_lighting_multi_if.sv | 39 +++
 rtl/ibis_lighting_multi.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ibis_lighting_multi_if.sv
// Pixel, result and light-table ports of ibis_lighting_multi.
// master = pixel source / table writer / result sink, slave = the lighting stage.
interface ibis_lighting_multi_if #(
    parameter int WIDTH    = 11,
    parameter int LIGHTS   = 4,
    parameter int CHANNELS = 3
);
    localparam int IDXW = (LIGHTS > 1) ? $clog2(LIGHTS) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        x;
    logic [WIDTH-1:0]        y;
    logic [8*CHANNELS-1:0]   value_in0;
    logic [8*CHANNELS-1:0]   value_in1;

    logic                    out_valid;
    logic                    out_ready;
    logic [8*CHANNELS-1:0]   value_out;

    logic                    cfg_we;
    logic                    cfg_ready;
    logic [IDXW-1:0]         cfg_index;
    logic [WIDTH-1:0]        cfg_origin_x;
    logic [WIDTH-1:0]        cfg_origin_y;
    logic [3:0]              cfg_attenuation;

    modport master (
        output in_valid, x, y, value_in0, value_in1, out_ready,
               cfg_we, cfg_index, cfg_origin_x, cfg_origin_y, cfg_attenuation,
        input  in_ready, out_valid, value_out, cfg_ready
    );

    modport slave (
        input  in_valid, x, y, value_in0, value_in1, out_ready,
               cfg_we, cfg_index, cfg_origin_x, cfg_origin_y, cfg_attenuation,
        output in_ready, out_valid, value_out, cfg_ready
    );
endinterface

// File: rtl/ibis_lighting_multi.sv
// Multi-light lighting stage: walks the light table per pixel, keeps the nearest hit
// coefficient and blends lit/unlit components. Optional IBIS_LIGHTING_MULTI_STATS_EN adds unlit_count.
module ibis_lighting_multi #(
    parameter int WIDTH    = 11,
    parameter int LIGHTS   = 4,
    parameter int CHANNELS = 3
) (
    input  logic                  aclk,
    input  logic                  areset,
    ibis_lighting_multi_if.slave  bus,
    output logic [15:0]           unlit_count
);
    localparam int IDXW = (LIGHTS > 1) ? $clog2(LIGHTS) : 1;
    localparam int DW   = 2*WIDTH + 1;

    typedef enum logic [2:0] {IDLE, SUB, SQR, EVAL, MIX, SUM, OUT} state_t;

    state_t                   state_q, state_d;

    logic [WIDTH-1:0]         org_x_q [LIGHTS];
    logic [WIDTH-1:0]         org_y_q [LIGHTS];
    logic [3:0]               att_q   [LIGHTS];

    logic [WIDTH-1:0]         x_q, y_q;
    logic [8*CHANNELS-1:0]    v0_q, v1_q;
    logic [IDXW-1:0]          idx_q;
    logic signed [WIDTH:0]    dx_q, dy_q;
    logic [2*WIDTH-1:0]       dxsq_q, dysq_q;
    logic [7:0]               best_q;
    logic                     seen_q;
    logic [7:0]               m0h_q [CHANNELS];
    logic [7:0]               m1h_q [CHANNELS];
    logic [8*CHANNELS-1:0]    value_out_q;

    logic                     accept_c;
    logic                     cfg_wr_c;
    logic                     last_c;
    logic                     out_hs_c;
    logic [DW-1:0]            dist_c;
    logic [8:0]               ev_c;

    // Returns {hit, coeff}; code 0 always hits with coeff 0, code F never hits.
    function automatic logic [8:0] eval_light(input logic [DW-1:0] d, input logic [3:0] a);
        logic       hit;
        logic [7:0] coeff;
        hit   = 1'b0;
        coeff = 8'h00;
        if (a == 4'h0) begin
            hit = 1'b1;
        end else if (a != 4'hF) begin
            hit   = ((d >> (2*WIDTH - int'(a))) == '0);
            coeff = 8'(d >> (2*WIDTH - 8 - int'(a)));
        end
        return {hit, coeff};
    endfunction

    // |v|^2 of a (WIDTH+1)-bit difference always fits in 2*WIDTH bits.
    function automatic logic [2*WIDTH-1:0] sq_mag(input logic signed [WIDTH:0] v);
        logic signed [2*WIDTH+1:0] ve;
        ve = v;
        return (2*WIDTH)'($unsigned(ve * ve));
    endfunction

    function automatic logic [7:0] mix_hi(input logic [7:0] a, input logic [7:0] b);
        return 8'((16'(a) * 16'(b)) >> 8);
    endfunction

    // Both terms are at most 255*k>>8 and 255*(255-k)>>8, so the sum stays below 255.
    function automatic logic [7:0] blend_sum(input logic [7:0] h0, input logic [7:0] h1);
        return h0 + h1;
    endfunction

    assign accept_c = (state_q == IDLE) && bus.in_valid;
    assign cfg_wr_c = (state_q == IDLE) && bus.cfg_we &&
                      ({1'b0, bus.cfg_index} < (IDXW+1)'(LIGHTS));
    assign last_c   = (idx_q == IDXW'(LIGHTS-1));
    assign out_hs_c = (state_q == OUT) && bus.out_ready;
    assign dist_c   = {1'b0, dxsq_q} + {1'b0, dysq_q};
    assign ev_c     = eval_light(dist_c, att_q[idx_q]);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.cfg_ready = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready  = 1'b1;
                bus.cfg_ready = 1'b1;
                if (accept_c) state_d = SUB;
            end
            SUB:  state_d = SQR;
            SQR:  state_d = EVAL;
            EVAL: state_d = last_c ? MIX : SUB;
            MIX:  state_d = SUM;
            SUM:  state_d = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                if (out_hs_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Light table and result register; the table write lands before a same-cycle pixel is evaluated.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < LIGHTS; i++) begin
                org_x_q[i] <= '0;
                org_y_q[i] <= '0;
                att_q[i]   <= 4'hF;
            end
            value_out_q <= '0;
        end else begin
            if (cfg_wr_c) begin
                org_x_q[bus.cfg_index] <= bus.cfg_origin_x;
                org_y_q[bus.cfg_index] <= bus.cfg_origin_y;
                att_q[bus.cfg_index]   <= bus.cfg_attenuation;
            end
            if (state_q == SUM) begin
                for (int c = 0; c < CHANNELS; c++)
                    value_out_q[8*c +: 8] <= seen_q ? blend_sum(m0h_q[c], m1h_q[c])
                                                    : v1_q[8*c +: 8];
            end
        end
    end

    always_ff @(posedge aclk) begin
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    x_q    <= bus.x;
                    y_q    <= bus.y;
                    v0_q   <= bus.value_in0;
                    v1_q   <= bus.value_in1;
                    idx_q  <= '0;
                    best_q <= 8'h00;
                    seen_q <= 1'b0;
                end
            end
            SUB: begin
                dx_q <= $signed({1'b0, x_q}) - $signed({1'b0, org_x_q[idx_q]});
                dy_q <= $signed({1'b0, y_q}) - $signed({1'b0, org_y_q[idx_q]});
            end
            SQR: begin
                dxsq_q <= sq_mag(dx_q);
                dysq_q <= sq_mag(dy_q);
            end
            EVAL: begin
                if (ev_c[8]) begin
                    if (!seen_q || (ev_c[7:0] < best_q)) best_q <= ev_c[7:0];
                    seen_q <= 1'b1;
                end
                if (!last_c) idx_q <= idx_q + IDXW'(1);
            end
            MIX: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    m0h_q[c] <= mix_hi(v0_q[8*c +: 8], 8'd255 - best_q);
                    m1h_q[c] <= mix_hi(v1_q[8*c +: 8], best_q);
                end
            end
            default: ;
        endcase
    end

    assign bus.value_out = value_out_q;

`ifdef IBIS_LIGHTING_MULTI_STATS_EN
    logic [15:0] unlit_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                                          unlit_q <= 16'h0000;
        else if (out_hs_c && !seen_q && unlit_q != 16'hFFFF) unlit_q <= unlit_q + 16'd1;
    end

    assign unlit_count = unlit_q;
`else
    assign unlit_count = 16'h0000;
`endif
endmodule
